// File: rtl/pad_mux_sequencer.sv
// Registered pad-group mux: routes one functional source (or the test path) to the pads,
// switching sources only through a handshaked request that parks the pads safe for SETTLE cycles.
module pad_mux_sequencer #(
    parameter int                NUM_SRC   = 4,
    parameter int                DATA_W    = 4,
    parameter int                CTL_W     = 5,
    parameter int                SETTLE    = 3,
    parameter int                RESET_SEL = 0,
    parameter logic [CTL_W-1:0]  SAFE_CTL  = CTL_W'(5'b00001),
    parameter int                SEL_W     = $clog2(NUM_SRC)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    input  logic [SEL_W-1:0]            req_sel,
    output logic                        req_ready,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    input  logic [CTL_W-1:0]            port_ctl,
    input  logic                        test_mode,
    input  logic [DATA_W-1:0]           test_data,
    input  logic [CTL_W-1:0]            test_ctl,
    output logic [DATA_W-1:0]           pad_data,
    output logic [CTL_W-1:0]            pad_ctl,
    output logic [SEL_W-1:0]            cur_sel,
    output logic                        busy,
    output logic                        done,
    output logic                        sel_err
);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [SEL_W-1:0]    pend_q, pend_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   pdata_q, pdata_d;
    logic [CTL_W-1:0]    pctl_q, pctl_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept;
    logic                sel_ok;
    logic [31:0]         sel_ext;
    logic [DATA_W-1:0]   src_mux;

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    // Widen before comparing so the range check stays meaningful when NUM_SRC is a power of two
    assign sel_ext   = 32'(req_sel);
    assign sel_ok    = sel_ext < 32'(NUM_SRC);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!sel_ok) begin
                        err_d = 1'b1;
                    end else if (req_sel == sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        pend_d  = req_sel;
                        state_d = DRAIN;
                        cnt_d   = 8'(SETTLE - 1);
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                    sel_d   = pend_q;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == DRAIN);
    end

    // Pads follow the source that will be current after this edge
    always_comb begin
        src_mux = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel_d == SEL_W'(i)) src_mux = src_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        pdata_d = src_mux;
        pctl_d  = port_ctl;
        if (test_mode) begin
            pdata_d = test_data;
            pctl_d  = test_ctl;
        end else if (state_d == DRAIN) begin
            pdata_d = '0;
            pctl_d  = SAFE_CTL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            pend_q  <= SEL_W'(RESET_SEL);
            sel_q   <= SEL_W'(RESET_SEL);
            pdata_q <= '0;
            pctl_q  <= SAFE_CTL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            pdata_q <= pdata_d;
            pctl_q  <= pctl_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign pad_data = pdata_q;
    assign pad_ctl  = pctl_q;
    assign cur_sel  = sel_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sel_err  = err_q;

endmodule

// File: tb/tb_pad_mux_sequencer.sv
// Scoreboarded directed bench: stimulus pushes the hand-computed post-edge outputs,
// a monitor pops one entry per edge for each instance and compares every output.
module tb_pad_mux_sequencer;

    typedef struct {
        int         tag;
        logic [3:0] d;
        logic [4:0] c;
        logic [2:0] sel;
        logic       busy;
        logic       done;
        logic       err;
        logic       rdy;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks   = 0;
    int   failures = 0;
    int   tag_a    = 0;
    int   tag_b    = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: NUM_SRC=4, SETTLE=3, RESET_SEL=0
    logic        a_rst, a_rv, a_tm, a_rdy, a_busy, a_done, a_err;
    logic [1:0]  a_rs, a_sel;
    logic [15:0] a_src;
    logic [4:0]  a_pctl, a_tctl, a_padc;
    logic [3:0]  a_td, a_padd;

    pad_mux_sequencer #(.NUM_SRC(4), .DATA_W(4), .CTL_W(5), .SETTLE(3),
                        .RESET_SEL(0), .SAFE_CTL(5'b00001)) u_a (
        .clk(clk), .rst(a_rst), .req_valid(a_rv), .req_sel(a_rs), .req_ready(a_rdy),
        .src_data(a_src), .port_ctl(a_pctl), .test_mode(a_tm), .test_data(a_td),
        .test_ctl(a_tctl), .pad_data(a_padd), .pad_ctl(a_padc), .cur_sel(a_sel),
        .busy(a_busy), .done(a_done), .sel_err(a_err));

    // Instance B: NUM_SRC=5 (3-bit select), SETTLE=1, RESET_SEL=4
    logic        b_rst, b_rv, b_tm, b_rdy, b_busy, b_done, b_err;
    logic [2:0]  b_rs, b_sel;
    logic [19:0] b_src;
    logic [4:0]  b_pctl, b_tctl, b_padc;
    logic [3:0]  b_td, b_padd;

    pad_mux_sequencer #(.NUM_SRC(5), .DATA_W(4), .CTL_W(5), .SETTLE(1),
                        .RESET_SEL(4), .SAFE_CTL(5'b00001)) u_b (
        .clk(clk), .rst(b_rst), .req_valid(b_rv), .req_sel(b_rs), .req_ready(b_rdy),
        .src_data(b_src), .port_ctl(b_pctl), .test_mode(b_tm), .test_data(b_td),
        .test_ctl(b_tctl), .pad_data(b_padd), .pad_ctl(b_padc), .cur_sel(b_sel),
        .busy(b_busy), .done(b_done), .sel_err(b_err));

    task automatic chk(input string nm, input int tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step %0d got %0h expected %0h", nm, tag, got, exp);
        end
    endtask

    // Monitor: registered outputs sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("A.pad_data", e.tag, 32'(a_padd), 32'(e.d));
            chk("A.pad_ctl",  e.tag, 32'(a_padc), 32'(e.c));
            chk("A.cur_sel",  e.tag, 32'(a_sel),  32'(e.sel));
            chk("A.busy",     e.tag, 32'(a_busy), 32'(e.busy));
            chk("A.done",     e.tag, 32'(a_done), 32'(e.done));
            chk("A.sel_err",  e.tag, 32'(a_err),  32'(e.err));
            chk("A.req_ready",e.tag, 32'(a_rdy),  32'(e.rdy));
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("B.pad_data", e.tag, 32'(b_padd), 32'(e.d));
            chk("B.pad_ctl",  e.tag, 32'(b_padc), 32'(e.c));
            chk("B.cur_sel",  e.tag, 32'(b_sel),  32'(e.sel));
            chk("B.busy",     e.tag, 32'(b_busy), 32'(e.busy));
            chk("B.done",     e.tag, 32'(b_done), 32'(e.done));
            chk("B.sel_err",  e.tag, 32'(b_err),  32'(e.err));
            chk("B.req_ready",e.tag, 32'(b_rdy),  32'(e.rdy));
        end
    end

    // Drive A for one edge and queue the outputs expected right after that edge
    task automatic step_a(input logic r, input logic v, input logic [1:0] s, input logic tm,
                          input logic [3:0] ed, input logic [4:0] ec, input logic [1:0] es,
                          input logic eb, input logic edn, input logic erdy);
        exp_t e;
        a_rst = r; a_rv = v; a_rs = s; a_tm = tm;
        tag_a++;
        e.tag = tag_a; e.d = ed; e.c = ec; e.sel = {1'b0, es};
        e.busy = eb; e.done = edn; e.err = 1'b0; e.rdy = erdy;
        qa.push_back(e);
        @(negedge clk);
    endtask

    task automatic step_b(input logic r, input logic v, input logic [2:0] s,
                          input logic [3:0] ed, input logic [4:0] ec, input logic [2:0] es,
                          input logic eb, input logic edn, input logic eer, input logic erdy);
        exp_t e;
        b_rst = r; b_rv = v; b_rs = s;
        tag_b++;
        e.tag = tag_b; e.d = ed; e.c = ec; e.sel = es;
        e.busy = eb; e.done = edn; e.err = eer; e.rdy = erdy;
        qb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        a_rst = 1'b1; a_rv = 1'b0; a_rs = 2'd0; a_tm = 1'b0;
        a_src = 16'hDCBA; a_pctl = 5'h16; a_td = 4'h9; a_tctl = 5'h1F;
        b_rst = 1'b1; b_rv = 1'b0; b_rs = 3'd0; b_tm = 1'b0;
        b_src = 20'h54321; b_pctl = 5'h0A; b_td = 4'h0; b_tctl = 5'h00;

        //     rst v  sel tm | data ctl   sel busy done rdy
        // reset routing
        step_a(1, 0, 2'd0, 0,  4'h0, 5'h01, 2'd0, 0, 0, 0);
        step_a(1, 0, 2'd0, 0,  4'h0, 5'h01, 2'd0, 0, 0, 0);
        step_a(0, 0, 2'd0, 0,  4'hA, 5'h16, 2'd0, 0, 0, 1);
        // switch to 2: three safe cycles, then C with done
        step_a(0, 1, 2'd2, 0,  4'h0, 5'h01, 2'd0, 1, 0, 0);
        step_a(0, 0, 2'd0, 0,  4'h0, 5'h01, 2'd0, 1, 0, 0);
        step_a(0, 0, 2'd0, 0,  4'h0, 5'h01, 2'd0, 1, 0, 0);
        step_a(0, 0, 2'd0, 0,  4'hC, 5'h16, 2'd2, 0, 1, 1);
        step_a(0, 0, 2'd0, 0,  4'hC, 5'h16, 2'd2, 0, 0, 1);
        // same select: done, no drain
        step_a(0, 1, 2'd2, 0,  4'hC, 5'h16, 2'd2, 0, 1, 1);
        step_a(0, 0, 2'd0, 0,  4'hC, 5'h16, 2'd2, 0, 0, 1);
        // test override during a drain to 1
        step_a(0, 1, 2'd1, 0,  4'h0, 5'h01, 2'd2, 1, 0, 0);
        step_a(0, 0, 2'd0, 1,  4'h9, 5'h1F, 2'd2, 1, 0, 0);
        step_a(0, 0, 2'd0, 1,  4'h9, 5'h1F, 2'd2, 1, 0, 0);
        step_a(0, 0, 2'd0, 1,  4'h9, 5'h1F, 2'd1, 0, 1, 1);
        step_a(0, 0, 2'd0, 0,  4'hB, 5'h16, 2'd1, 0, 0, 1);
        // reset mid-drain abandons the switch to 3
        step_a(0, 1, 2'd3, 0,  4'h0, 5'h01, 2'd1, 1, 0, 0);
        step_a(1, 0, 2'd0, 0,  4'h0, 5'h01, 2'd0, 0, 0, 0);
        step_a(0, 0, 2'd0, 0,  4'hA, 5'h16, 2'd0, 0, 0, 1);
        // back-to-back 1 then 3 with valid held; second accepted at k+4
        step_a(0, 1, 2'd1, 0,  4'h0, 5'h01, 2'd0, 1, 0, 0);
        step_a(0, 1, 2'd3, 0,  4'h0, 5'h01, 2'd0, 1, 0, 0);
        step_a(0, 1, 2'd3, 0,  4'h0, 5'h01, 2'd0, 1, 0, 0);
        step_a(0, 1, 2'd3, 0,  4'hB, 5'h16, 2'd1, 0, 1, 1);
        step_a(0, 1, 2'd3, 0,  4'h0, 5'h01, 2'd1, 1, 0, 0);
        step_a(0, 0, 2'd0, 0,  4'h0, 5'h01, 2'd1, 1, 0, 0);
        step_a(0, 0, 2'd0, 0,  4'h0, 5'h01, 2'd1, 1, 0, 0);
        step_a(0, 0, 2'd0, 0,  4'hD, 5'h16, 2'd3, 0, 1, 1);
        step_a(0, 0, 2'd0, 0,  4'hD, 5'h16, 2'd3, 0, 0, 1);

        //     rst v  sel  | data ctl   sel  busy done err rdy
        step_b(1, 0, 3'd0, 4'h0, 5'h01, 3'd4, 0, 0, 0, 0);
        step_b(0, 0, 3'd0, 4'h5, 5'h0A, 3'd4, 0, 0, 0, 1);
        // out-of-range selects rejected, 5 is the first invalid index
        step_b(0, 1, 3'd7, 4'h5, 5'h0A, 3'd4, 0, 0, 1, 1);
        step_b(0, 1, 3'd5, 4'h5, 5'h0A, 3'd4, 0, 0, 1, 1);
        step_b(0, 1, 3'd4, 4'h5, 5'h0A, 3'd4, 0, 1, 0, 1);
        // SETTLE=1: exactly one safe cycle
        step_b(0, 1, 3'd0, 4'h0, 5'h01, 3'd4, 1, 0, 0, 0);
        step_b(0, 0, 3'd0, 4'h1, 5'h0A, 3'd0, 0, 1, 0, 1);
        step_b(0, 0, 3'd0, 4'h1, 5'h0A, 3'd0, 0, 0, 0, 1);

        for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
        checks++;
        if (qa.size() > 0 || qb.size() > 0) begin
            failures++;
            $display("FAIL drain_queue pending %0d expected 0", qa.size() + qb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
